// File: rtl/fp_to_int_seq_converter.sv
// fp_to_int_seq_converter
// Multi-cycle float-to-signed-integer converter. A float {sign, exp, man}
// is classified, shifted one bit per cycle to integer alignment, rounded
// with one of four modes and saturated into a signed INT_W result.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake; in_ready is high only in IDLE
//   x, round_mode       : operand and rounding mode, captured on accept
//                         (00 RTZ, 01 RNE, 10 toward +inf, 11 toward -inf)
//   out_valid/out_ready : result handshake; result held until accepted
//   r                   : signed result
//   negative, zero, overflow, inf, nan, subnormal, inexact : result flags
module fp_to_int_seq_converter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x,
  input  logic [1:0]             round_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       r,
  output logic                   negative,
  output logic                   zero,
  output logic                   overflow,
  output logic                   inf,
  output logic                   nan,
  output logic                   subnormal,
  output logic                   inexact
);

  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int SIG_W = INT_W + 2;
  localparam int N_W   = $clog2(INT_W + MAN_W + 2);
  localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [N_W-1:0]   N_ONE   = {{(N_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    SHIFT    = 3'd2,
    ROUND    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t             state_r;
  logic               sign_r;
  logic [EXP_W-1:0]   exp_r;
  logic [MAN_W-1:0]   man_r;
  logic [1:0]         mode_r;
  logic [SIG_W-1:0]   sig_r;
  logic               guard_r;
  logic               sticky_r;
  logic [N_W-1:0]     n_r;
  logic               left_r;
  logic               sat_r;
  logic               inf_r;
  logic               nan_r;
  logic               sub_r;

  int                 e_s;
  logic [SIG_W-1:0]   cls_sig_s;
  logic               cls_guard_s;
  logic               cls_sticky_s;
  logic [N_W-1:0]     cls_n_s;
  logic               cls_left_s;
  logic               cls_sat_s;
  logic               cls_inf_s;
  logic               cls_nan_s;
  logic               cls_sub_s;

  logic               inc_s;
  logic [SIG_W-1:0]   mag_s;
  logic [INT_W-1:0]   res_s;
  logic               ovf_s;
  logic               inexact_s;

  // Classification of the latched operand: initial significand, guard/sticky and shift plan.
  always_comb begin
    e_s          = int'({1'b0, exp_r}) - BIAS;
    cls_sig_s    = {SIG_W{1'b0}};
    cls_guard_s  = 1'b0;
    cls_sticky_s = 1'b0;
    cls_n_s      = {N_W{1'b0}};
    cls_left_s   = 1'b0;
    cls_sat_s    = 1'b0;
    cls_inf_s    = 1'b0;
    cls_nan_s    = 1'b0;
    cls_sub_s    = 1'b0;
    if (exp_r == {EXP_W{1'b0}}) begin
      if (man_r == {MAN_W{1'b0}}) begin
        cls_sig_s = {SIG_W{1'b0}};
      end else begin
        // Subnormal: magnitude strictly inside (0,1), only sticky survives.
        cls_sub_s    = 1'b1;
        cls_sticky_s = 1'b1;
      end
    end else if (exp_r == {EXP_W{1'b1}}) begin
      cls_sat_s = 1'b1;
      if (man_r == {MAN_W{1'b0}}) begin
        cls_inf_s = 1'b1;
      end else begin
        cls_nan_s = 1'b1;
      end
    end else if (e_s >= INT_W - 1) begin
      // -2^(INT_W-1) is the one representable value at this exponent.
      if ((e_s == INT_W - 1) && (man_r == {MAN_W{1'b0}}) && sign_r) begin
        cls_sig_s = {2'b00, MIN_NEG};
      end else begin
        cls_sat_s = 1'b1;
      end
    end else if (e_s == -32'sd1) begin
      cls_guard_s  = 1'b1;
      cls_sticky_s = |man_r;
    end else if (e_s < -32'sd1) begin
      cls_sticky_s = 1'b1;
    end else begin
      cls_sig_s = {{(SIG_W-MAN_W-1){1'b0}}, 1'b1, man_r};
      if (e_s > MAN_W) begin
        cls_left_s = 1'b1;
        cls_n_s    = N_W'(e_s - MAN_W);
      end else if (e_s < MAN_W) begin
        cls_n_s    = N_W'(MAN_W - e_s);
      end else begin
        cls_n_s    = {N_W{1'b0}};
      end
    end
  end

  // Rounding increment, saturation and final signed result.
  always_comb begin
    case (mode_r)
      2'b00:   inc_s = 1'b0;
      2'b01:   inc_s = guard_r & (sticky_r | sig_r[0]);
      2'b10:   inc_s = ~sign_r & (guard_r | sticky_r);
      2'b11:   inc_s = sign_r & (guard_r | sticky_r);
      default: inc_s = 1'b0;
    endcase
    mag_s = sig_r + {{(SIG_W-1){1'b0}}, inc_s};
    res_s = {INT_W{1'b0}};
    ovf_s = 1'b0;
    if (sat_r) begin
      ovf_s = 1'b1;
      res_s = (sign_r && !nan_r) ? MIN_NEG : MAX_POS;
    end else if ((mag_s > {2'b00, MAX_POS}) && !(sign_r && (mag_s == {2'b00, MIN_NEG}))) begin
      ovf_s = 1'b1;
      res_s = sign_r ? MIN_NEG : MAX_POS;
    end else begin
      res_s = sign_r ? -mag_s[INT_W-1:0] : mag_s[INT_W-1:0];
    end
    inexact_s = (guard_r | sticky_r) & ~ovf_s;
  end

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= {INT_W{1'b0}};
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      inf       <= 1'b0;
      nan       <= 1'b0;
      subnormal <= 1'b0;
      inexact   <= 1'b0;
      sign_r    <= 1'b0;
      exp_r     <= {EXP_W{1'b0}};
      man_r     <= {MAN_W{1'b0}};
      mode_r    <= 2'b00;
      sig_r     <= {SIG_W{1'b0}};
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
      n_r       <= {N_W{1'b0}};
      left_r    <= 1'b0;
      sat_r     <= 1'b0;
      inf_r     <= 1'b0;
      nan_r     <= 1'b0;
      sub_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_r   <= x[EXP_W+MAN_W];
            exp_r    <= x[EXP_W+MAN_W-1:MAN_W];
            man_r    <= x[MAN_W-1:0];
            mode_r   <= round_mode;
            in_ready <= 1'b0;
            state_r  <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          sig_r    <= cls_sig_s;
          guard_r  <= cls_guard_s;
          sticky_r <= cls_sticky_s;
          n_r      <= cls_n_s;
          left_r   <= cls_left_s;
          sat_r    <= cls_sat_s;
          inf_r    <= cls_inf_s;
          nan_r    <= cls_nan_s;
          sub_r    <= cls_sub_s;
          state_r  <= (cls_n_s != {N_W{1'b0}}) ? SHIFT : ROUND;
        end
        SHIFT: begin
          if (left_r) begin
            sig_r <= {sig_r[SIG_W-2:0], 1'b0};
          end else begin
            // Shifted-out bit becomes guard; the previous guard folds into sticky.
            sig_r    <= {1'b0, sig_r[SIG_W-1:1]};
            guard_r  <= sig_r[0];
            sticky_r <= sticky_r | guard_r;
          end
          n_r <= n_r - N_ONE;
          if (n_r == N_ONE) begin
            state_r <= ROUND;
          end
        end
        ROUND: begin
          r         <= res_s;
          negative  <= res_s[INT_W-1];
          zero      <= (res_s == {INT_W{1'b0}});
          overflow  <= ovf_s;
          inf       <= inf_r;
          nan       <= nan_r;
          subnormal <= sub_r;
          inexact   <= inexact_s;
          state_r   <= DONE;
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE, then waits for out_ready.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_seq_converter.sv
// Directed self-checking bench for fp_to_int_seq_converter (default params).
module tb_fp_to_int_seq_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [1:0]  round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
  logic        negative, zero, overflow, inf, nan, subnormal, inexact;
  logic [6:0]  flags_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign flags_s = {negative, zero, overflow, inf, nan, subnormal, inexact};

  fp_to_int_seq_converter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r          (r),
    .negative   (negative),
    .zero       (zero),
    .overflow   (overflow),
    .inf        (inf),
    .nan        (nan),
    .subnormal  (subnormal),
    .inexact    (inexact)
  );

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Launch one operand, scramble inputs after accept, wait for out_valid.
  task automatic do_conv(input logic [15:0] xv, input logic [1:0] mode, output int lat);
    @(negedge clk);
    check_val("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    x          = xv;
    round_mode = mode;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    x          = 16'hFFFF;
    round_mode = ~mode;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      check_val("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("out_valid_dropped", {31'd0, out_valid}, 32'd0);
    check_val("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] xv;
    logic [1:0]  mode;
    logic [15:0] exp_r;
    logic [6:0]  exp_f;  // {neg, zero, ovf, inf, nan, sub, inexact}
    int          exp_lat; // -1: latency not checked
  } vec_t;

  vec_t vecs[15];

  initial begin
    int lat;
    logic seen;
    vecs = '{
      '{16'h4A40, 2'b01, 16'h000C, 7'b0000001, 10},  // 12.5 RNE
      '{16'h4A40, 2'b10, 16'h000D, 7'b0000001, 10},  // 12.5 +inf
      '{16'hCA40, 2'b11, 16'hFFF3, 7'b1000001, 10},  // -12.5 -inf
      '{16'hCA40, 2'b00, 16'hFFF4, 7'b1000001, 10},  // -12.5 RTZ
      '{16'h4AC0, 2'b01, 16'h000E, 7'b0000001, 10},  // 13.5 RNE (odd lsb)
      '{16'h4900, 2'b01, 16'h000A, 7'b0000000, 10},  // 10.0 exact
      '{16'h3800, 2'b01, 16'h0000, 7'b0100001, 3},   // 0.5 RNE
      '{16'h3E00, 2'b01, 16'h0002, 7'b0000001, 13},  // 1.5 RNE
      '{16'h3800, 2'b10, 16'h0001, 7'b0000001, 3},   // 0.5 +inf
      '{16'hF800, 2'b00, 16'h8000, 7'b1000000, -1},  // -32768
      '{16'h7800, 2'b00, 16'h7FFF, 7'b0010000, 3},   // +32768 overflow
      '{16'h7C00, 2'b00, 16'h7FFF, 7'b0011000, 3},   // +inf
      '{16'hFC00, 2'b01, 16'h8000, 7'b1011000, 3},   // -inf
      '{16'h7E00, 2'b00, 16'h7FFF, 7'b0010100, 3},   // nan
      '{16'h8001, 2'b11, 16'hFFFF, 7'b1000011, 3}    // -subnormal toward -inf
    };

    reset = 1'b1; in_valid = 1'b0; x = 16'h0000; round_mode = 2'b00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_r", {16'd0, r}, 32'd0);
    check_val("rst_flags", {25'd0, flags_s}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      do_conv(vecs[i].xv, vecs[i].mode, lat);
      check_val($sformatf("r_%0d_%04h", i, vecs[i].xv), {16'd0, r}, {16'd0, vecs[i].exp_r});
      check_val($sformatf("flags_%0d_%04h", i, vecs[i].xv), {25'd0, flags_s}, {25'd0, vecs[i].exp_f});
      if (vecs[i].exp_lat >= 0) begin
        check_val($sformatf("lat_%0d_%04h", i, vecs[i].xv), lat, vecs[i].exp_lat);
      end
      release_out();
    end

    // Backpressure: result held, no re-accept while DONE.
    do_conv(16'h4A40, 2'b01, lat);
    in_valid = 1'b1;
    x = 16'h3C00;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_val("bp_r_stable", {16'd0, r}, 32'h0000000C);
      check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check_val("bp_no_extra_result", {31'd0, seen}, 32'd0);

    // Reset during SHIFT aborts the conversion.
    @(negedge clk);
    x = 16'h4A40; round_mode = 2'b01; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_r", {16'd0, r}, 32'd0);
    check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check_val("midrst_no_stale", {31'd0, seen}, 32'd0);

    // Recovery after abort.
    do_conv(16'h3E00, 2'b01, lat);
    check_val("post_rst_r", {16'd0, r}, 32'd2);
    check_val("post_rst_lat", lat, 32'd13);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
